// File: rtl/count_seq_pkg.sv
// Shared types and constants for the wrap-range counter sequencer.
package count_seq_pkg;

  // Sequencer states; the encoding is also visible on the state_dbg output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Reset values of the lo/hi bounds (wrap is 15 -> 5 out of reset).
  localparam int DEF_LO_C = 5;
  localparam int DEF_HI_C = 15;

endpackage

// File: rtl/count_seq_ctrl_range_counter.sv
// Count register for the wrap-range counter.
// load has priority over en; when enabled at hi the count reloads load_val,
// so it increments modulo the range and never runs past hi.
module range_counter #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  // A wrap is an enabled advance taken while sitting on the upper bound.
  assign wrap = en && (count == hi);

  // Count register: load, wrap back to load_val, or increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (count == hi) begin
        count <= load_val;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer for the wrap-range up-counter: bounds, lap budget, run/pause/stop.
// Optional feature macro COUNT_SEQ_STEP_EN: when defined, step in PAUSE
// advances the count once (with wrap, lap and DONE handling); otherwise the
// step input is ignored.
// Command strobes are sampled every cycle with priority stop > pause > start
// > step; a command that has no meaning in the current state is ignored and
// does not block lower-priority commands.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LAP_W  = 4,
  parameter int DEF_LO = DEF_LO_C,
  parameter int DEF_HI = DEF_HI_C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [LAP_W-1:0] cfg_laps,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             step,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             lap_pulse,
  output logic             done,
  output logic             cfg_err,
  output logic [1:0]       state_dbg
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [LAP_W-1:0] laps_q, lap_cnt_q;
  logic [LAP_W:0]   lap_next;
  logic             in_idle_done, start_idle, do_step, cnt_en;
  logic             wrap, final_wrap, cfg_ok, cfg_rej;
  logic             ctr_load;
  logic [WIDTH-1:0] ctr_load_val;
  logic             busy_d, paused_d, done_d;

  assign state_dbg = state_q;

  range_counter #(
    .WIDTH   (WIDTH),
    .RST_VAL (WIDTH'(DEF_LO))
  ) u_range_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .en       (cnt_en),
    .hi       (hi_q),
    .count    (count),
    .wrap     (wrap)
  );

`ifdef COUNT_SEQ_STEP_EN
  // Step only acts in PAUSE and only when no higher-priority command is present.
  assign do_step = !stop && !start && step && (state_q == ST_PAUSE);
`else
  logic unused_step;
  assign unused_step = step;
  assign do_step     = 1'b0;
`endif

  // Command decode, config check and counter control.
  always_comb begin
    in_idle_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    start_idle   = !stop && start && in_idle_done;
    // pause freezes the count on the same edge it is sampled.
    cnt_en       = ((state_q == ST_RUN) && !stop && !pause) || do_step;
    lap_next     = {1'b0, lap_cnt_q} + (LAP_W + 1)'(1);
    final_wrap   = wrap && (laps_q != '0) && (lap_next == {1'b0, laps_q});
    // A write racing an accepted start would land in RUN, so it is refused.
    cfg_ok       = cfg_we && in_idle_done && !start_idle && (cfg_lo <= cfg_hi);
    cfg_rej      = cfg_we && !cfg_ok;
    ctr_load     = 1'b0;
    ctr_load_val = lo_q;
    if (cfg_ok && ((state_q == ST_IDLE) || stop)) begin
      ctr_load     = 1'b1;
      ctr_load_val = cfg_lo;
    end else if (stop || start_idle) begin
      ctr_load     = 1'b1;
      ctr_load_val = lo_q;
    end else if (final_wrap) begin
      // The last lap leaves the count parked on hi.
      ctr_load     = 1'b1;
      ctr_load_val = hi_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (pause)           state_d = ST_PAUSE;
          else if (final_wrap) state_d = ST_DONE;
        end
        ST_PAUSE: begin
          if (start)           state_d = ST_RUN;
          else if (final_wrap) state_d = ST_DONE;
        end
        ST_DONE:  if (start) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the status flags come out of flops.
  always_comb begin
    busy_d   = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    paused_d = (state_d == ST_PAUSE);
    done_d   = (state_d == ST_DONE);
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy      <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
      lap_pulse <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      paused    <= paused_d;
      done      <= done_d;
      lap_pulse <= wrap;
      cfg_err   <= cfg_rej;
    end
  end

  // Bound/budget registers and the saturating lap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q      <= WIDTH'(DEF_LO);
      hi_q      <= WIDTH'(DEF_HI);
      laps_q    <= '0;
      lap_cnt_q <= '0;
    end else begin
      if (cfg_ok) begin
        lo_q   <= cfg_lo;
        hi_q   <= cfg_hi;
        laps_q <= cfg_laps;
      end
      if (stop || start_idle) begin
        lap_cnt_q <= '0;
      end else if (wrap && (lap_cnt_q != '1)) begin
        lap_cnt_q <= lap_cnt_q + LAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with hand-computed expected values.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [3:0] cfg_lo, cfg_hi, cfg_laps;
  logic       start, stop, pause, step;
  logic [3:0] count;
  logic       busy, paused, lap_pulse, done, cfg_err;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  count_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_laps  (cfg_laps),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .step      (step),
    .count     (count),
    .busy      (busy),
    .paused    (paused),
    .lap_pulse (lap_pulse),
    .done      (done),
    .cfg_err   (cfg_err),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs set beforehand are sampled, then strobes are cleared.
  task automatic tick();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    step   = 1'b0;
  endtask

  task automatic do_cfg(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] laps);
    cfg_we   = 1'b1;
    cfg_lo   = lo;
    cfg_hi   = hi;
    cfg_laps = laps;
  endtask

  initial begin
    reset = 1'b1;
    cfg_we = 0; cfg_lo = 0; cfg_hi = 0; cfg_laps = 0;
    start = 0; stop = 0; pause = 0; step = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_count", count, 5);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_lap", lap_pulse, 0);
    check_val("rst_err", cfg_err, 0);
    reset = 1'b0;
    tick();

    // 1: default range 5..15, wrap 15 -> 5
    start = 1; tick();
    check_val("t1_count0", count, 5);
    check_val("t1_busy", busy, 1);
    for (int v = 6; v <= 15; v++) begin
      tick();
      check_val("t1_count", count, v);
      check_val("t1_lap0", lap_pulse, 0);
    end
    tick();
    check_val("t1_wrap_count", count, 5);
    check_val("t1_wrap_lap", lap_pulse, 1);

    // 2: lo=2 hi=4 laps=2
    stop = 1; tick();
    do_cfg(2, 4, 2); tick();
    check_val("t2_cfg_count", count, 2);
    check_val("t2_cfg_err", cfg_err, 0);
    start = 1; tick();
    check_val("t2_c0", count, 2);
    tick(); check_val("t2_c1", count, 3);
    tick(); check_val("t2_c2", count, 4);
    tick(); check_val("t2_c3", count, 2); check_val("t2_lap1", lap_pulse, 1);
    tick(); check_val("t2_c4", count, 3); check_val("t2_lap_off", lap_pulse, 0);
    tick(); check_val("t2_c5", count, 4);
    tick();
    check_val("t2_done_count", count, 4);
    check_val("t2_done", done, 1);
    check_val("t2_lap2", lap_pulse, 1);
    check_val("t2_busy", busy, 0);
    tick();
    check_val("t2_hold_count", count, 4);
    check_val("t2_hold_done", done, 1);
    check_val("t2_hold_lap", lap_pulse, 0);

    // 3: pause at 7, hold, resume
    do_cfg(5, 15, 0); tick();
    check_val("t3_cfg_err", cfg_err, 0);
    start = 1; tick();
    check_val("t3_c0", count, 5);
    tick(); tick();
    check_val("t3_c7", count, 7);
    pause = 1; tick();
    check_val("t3_pause_count", count, 7);
    check_val("t3_paused", paused, 1);
    check_val("t3_pause_busy", busy, 1);
    repeat (4) tick();
    check_val("t3_hold_count", count, 7);
    start = 1; tick();
    check_val("t3_resume_count", count, 7);
    check_val("t3_resume_paused", paused, 0);
    tick(); check_val("t3_c8", count, 8);
    tick(); check_val("t3_c9", count, 9);

    // 4: rejected config writes
    do_cfg(1, 2, 0); tick();
    check_val("t4_run_err", cfg_err, 1);
    check_val("t4_run_count", count, 10);
    tick();
    check_val("t4_err_clear", cfg_err, 0);
    check_val("t4_count11", count, 11);
    stop = 1; tick();
    check_val("t4_stop_count", count, 5);
    do_cfg(9, 3, 0); tick();
    check_val("t4_bad_err", cfg_err, 1);
    check_val("t4_bad_count", count, 5);
    do_cfg(1, 2, 0); start = 1; tick();
    check_val("t4_race_err", cfg_err, 1);
    check_val("t4_race_count", count, 5);
    tick(); tick(); tick();
    check_val("t4_bounds_kept", count, 8);

    // 5: stop+start together, then async reset mid-run
    stop = 1; start = 1; tick();
    check_val("t5_count", count, 5);
    check_val("t5_busy", busy, 0);
    check_val("t5_state", state_dbg, 0);
    start = 1; tick(); tick(); tick();
    check_val("t5_run_count", count, 7);
    reset = 1'b1;
    #1;
    check_val("t5_rst_count", count, 5);
    check_val("t5_rst_busy", busy, 0);
    check_val("t5_rst_state", state_dbg, 0);
    tick();
    reset = 1'b0;
    tick();

    // 6: step in PAUSE
    start = 1; tick();
    repeat (9) tick();
    check_val("t6_c14", count, 14);
    pause = 1; tick();
    check_val("t6_paused", paused, 1);
    step = 1; tick();
`ifdef COUNT_SEQ_STEP_EN
    check_val("t6_step1", count, 15);
`else
    check_val("t6_step1", count, 14);
`endif
    step = 1; tick();
`ifdef COUNT_SEQ_STEP_EN
    check_val("t6_step2", count, 5);
    check_val("t6_step2_lap", lap_pulse, 1);
`else
    check_val("t6_step2", count, 14);
    check_val("t6_step2_lap", lap_pulse, 0);
`endif
    check_val("t6_still_paused", paused, 1);

    // 7: lo == hi, wrap every cycle, three laps
    stop = 1; tick();
    do_cfg(6, 6, 3); tick();
    check_val("t7_cfg_count", count, 6);
    start = 1; tick();
    check_val("t7_c0", count, 6);
    check_val("t7_lap0", lap_pulse, 0);
    tick(); check_val("t7_lap1", lap_pulse, 1); check_val("t7_done1", done, 0);
    tick(); check_val("t7_lap2", lap_pulse, 1); check_val("t7_done2", done, 0);
    tick();
    check_val("t7_lap3", lap_pulse, 1);
    check_val("t7_done3", done, 1);
    check_val("t7_count", count, 6);
    tick();
    check_val("t7_lap_off", lap_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
